// File: rtl/lcd_cmd_issuer.sv
// Buffers host commands and issues them one at a time to the LCD image controller.
// Optional LCD_ISSUER_AUTOWRITE_EN: issue an automatic Write after AW_TIMEOUT idle cycles.
module lcd_cmd_issuer #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned GUARD      = 2
`ifdef LCD_ISSUER_AUTOWRITE_EN
    ,
    parameter int unsigned AW_TIMEOUT = 16
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] in_cmd,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] cmd,
    output logic       cmd_valid,
    input  logic       busy,
    input  logic       done,
    output logic       seq_done,
    output logic       err_illegal,
    output logic [7:0] issued_cnt
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned GW = (GUARD > 1) ? $clog2(GUARD + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_FREE,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    state_t        r_state;
    logic [3:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [GW-1:0] r_guard;
    logic [3:0]    r_cmd;
    logic          r_cmd_valid;
    logic          r_in_ready;
    logic          r_seq_done;
    logic          r_err;
    logic [7:0]    r_issued;

    logic          w_push;
    logic          w_illegal;
    logic          w_store;
    logic          w_pop;
    logic          w_fifo_issue;
    logic          w_aw_fire;
    logic          w_auto_issue;
    logic          w_enter_finish;
    logic [CW-1:0] w_count_nxt;
    logic          w_full_nxt;
    logic          w_in_ready_nxt;
    logic [3:0]    w_head;

    assign w_push         = in_valid && r_in_ready;
    assign w_illegal      = in_cmd[3] && in_cmd[2];
    assign w_store        = w_push && !w_illegal;
    assign w_pop          = (r_state == S_ISSUE) && !w_auto_issue;
    assign w_head         = r_mem[r_rd_ptr];
    assign w_count_nxt    = r_count + CW'(w_store) - CW'(w_pop);
    assign w_full_nxt     = (w_count_nxt == CW'(DEPTH));
    assign w_fifo_issue   = (r_state == S_IDLE) && (r_count != '0) && !busy;
    assign w_enter_finish = (r_state == S_WAIT_DONE) && done;

    // A full FIFO may still take a push in ISSUE because the head pops in that same cycle.
    assign w_in_ready_nxt = (!w_full_nxt || w_fifo_issue) && !w_enter_finish
                            && (r_state != S_FINISH);

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= in_cmd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (r_state == S_FINISH) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

`ifdef LCD_ISSUER_AUTOWRITE_EN
    localparam int unsigned IW = $clog2(AW_TIMEOUT + 1);

    logic [IW-1:0] r_idle_cnt;
    logic          r_auto;
    logic          w_idle_armed;

    // Only reachable before any Write: a Write never returns the FSM to IDLE.
    assign w_idle_armed = (r_state == S_IDLE) && (r_count == '0) && (r_issued != '0) && !w_push;
    assign w_aw_fire    = w_idle_armed && !busy && (r_idle_cnt >= IW'(AW_TIMEOUT - 1));
    assign w_auto_issue = r_auto;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idle_cnt <= '0;
            r_auto     <= 1'b0;
        end else begin
            if (!w_idle_armed) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != IW'(AW_TIMEOUT)) begin
                r_idle_cnt <= r_idle_cnt + IW'(1);
            end
            if (w_aw_fire) begin
                r_auto <= 1'b1;
            end else if (w_fifo_issue) begin
                r_auto <= 1'b0;
            end
        end
    end
`else
    assign w_aw_fire    = 1'b0;
    assign w_auto_issue = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_guard     <= '0;
            r_cmd       <= 4'd0;
            r_cmd_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_seq_done  <= 1'b0;
            r_err       <= 1'b0;
            r_issued    <= 8'd0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_in_ready  <= w_in_ready_nxt;
            if (w_push && w_illegal) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_fifo_issue) begin
                        r_state     <= S_ISSUE;
                        r_cmd       <= w_head;
                        r_cmd_valid <= 1'b1;
                    end else if (w_aw_fire) begin
                        r_state     <= S_ISSUE;
                        r_cmd       <= 4'd0;
                        r_cmd_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (r_issued != 8'hFF) begin
                        r_issued <= r_issued + 8'd1;
                    end
                    r_guard <= '0;
                    r_state <= (r_cmd == 4'd0) ? S_WAIT_DONE : S_WAIT_ACK;
                end
                // Give the controller time to raise busy before sampling it.
                S_WAIT_ACK: begin
                    if (r_guard >= GW'(GUARD - 1)) begin
                        r_state <= S_WAIT_FREE;
                    end else begin
                        r_guard <= r_guard + GW'(1);
                    end
                end
                S_WAIT_FREE: begin
                    if (!busy) begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT_DONE: begin
                    if (done) begin
                        r_state    <= S_FINISH;
                        r_seq_done <= 1'b1;
                    end
                end
                S_FINISH: begin
                    r_seq_done <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd         = r_cmd;
    assign cmd_valid   = r_cmd_valid;
    assign in_ready    = r_in_ready;
    assign seq_done    = r_seq_done;
    assign err_illegal = r_err;
    assign issued_cnt  = r_issued;

endmodule

// File: tb/tb_lcd_cmd_issuer.sv
// Directed self-checking bench for lcd_cmd_issuer; exercises LCD_ISSUER_AUTOWRITE_EN when defined.
module tb_lcd_cmd_issuer;

    logic       clk;
    logic       reset;
    logic [3:0] in_cmd;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       done;
    logic       seq_done;
    logic       err_illegal;
    logic [7:0] issued_cnt;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_dbl    = 0;
    logic       prev_valid = 1'b0;
    logic [3:0] strobes[$];
    logic [3:0] got;

    lcd_cmd_issuer dut (
        .clk        (clk),
        .reset      (reset),
        .in_cmd     (in_cmd),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .busy       (busy),
        .done       (done),
        .seq_done   (seq_done),
        .err_illegal(err_illegal),
        .issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    // Log every strobe and count strobes on consecutive cycles.
    always @(negedge clk) begin
        if (!reset) begin
            prev_valid = 1'b0;
        end else begin
            if (cmd_valid) begin
                strobes.push_back(cmd);
                if (prev_valid) n_dbl++;
            end
            prev_valid = cmd_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic b);
        reset    = 1'b0;
        in_valid = 1'b0;
        in_cmd   = 4'd0;
        done     = 1'b0;
        busy     = b;
        repeat (3) tick();
        strobes.delete();
        reset = 1'b1;
        tick();
    endtask

    task automatic push(input logic [3:0] c);
        int k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        n_checks++;
        if (k >= 50) $display("FAIL push_ready_timeout code=%0d got in_ready=0 want 1", c);
        else n_pass++;
        in_valid = 1'b1;
        in_cmd   = c;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int k = 0;
        while (strobes.size() < n && k < budget) begin
            tick();
            k++;
        end
        n_checks++;
        if (strobes.size() < n) $display("FAIL strobe_timeout got %0d strobes want %0d", strobes.size(), n);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_checks++; if (cmd_valid !== 1'b0) $display("FAIL rst_cmd_valid got %0b want 0", cmd_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %0b want 0", in_ready); else n_pass++;
        n_checks++; if (cmd !== 4'd0) $display("FAIL rst_cmd got %0d want 0", cmd); else n_pass++;
        n_checks++; if (seq_done !== 1'b0) $display("FAIL rst_seq_done got %0b want 0", seq_done); else n_pass++;
        n_checks++; if (err_illegal !== 1'b0) $display("FAIL rst_err got %0b want 0", err_illegal); else n_pass++;
        n_checks++; if (issued_cnt !== 8'd0) $display("FAIL rst_issued got %0d want 0", issued_cnt); else n_pass++;
        reset = 1'b1;
        tick();
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_release_in_ready got %0b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_latency();
        do_reset(1'b0);
        in_valid = 1'b1;
        in_cmd   = 4'd7;
        tick();
        in_valid = 1'b0;
        n_checks++; if (cmd_valid !== 1'b0) $display("FAIL lat_early got %0b want 0", cmd_valid); else n_pass++;
        tick();
        n_checks++; if (cmd_valid !== 1'b1) $display("FAIL lat_strobe got %0b want 1", cmd_valid); else n_pass++;
        n_checks++; if (cmd !== 4'd7) $display("FAIL lat_cmd got %0d want 7", cmd); else n_pass++;
        done = 1'b1;
        tick();
        done = 1'b0;
        n_checks++; if (cmd_valid !== 1'b0) $display("FAIL lat_one_cycle got %0b want 0", cmd_valid); else n_pass++;
        n_checks++; if (cmd !== 4'd7) $display("FAIL lat_cmd_hold got %0d want 7", cmd); else n_pass++;
        n_checks++; if (issued_cnt !== 8'd1) $display("FAIL lat_issued got %0d want 1", issued_cnt); else n_pass++;
        repeat (10) tick();
        n_checks++; if (seq_done !== 1'b0) $display("FAIL stray_done_seq got %0b want 0", seq_done); else n_pass++;
    endtask

    task automatic test_busy_hold();
        do_reset(1'b1);
        push(4'd3);
        push(4'd5);
        push(4'd0);
        repeat (67) tick();
        n_checks++; if (strobes.size() != 0) $display("FAIL busy_block got %0d strobes want 0", strobes.size()); else n_pass++;
        busy = 1'b0;
        wait_strobes(3, 60);
        tick();
        for (int i = 0; i < 3; i++) begin
            got = (strobes.size() > i) ? strobes[i] : 4'hx;
            n_checks++;
            if (got !== ((i == 0) ? 4'd3 : (i == 1) ? 4'd5 : 4'd0))
                $display("FAIL busy_order[%0d] got %0d want %0d", i, got, (i == 0) ? 3 : (i == 1) ? 5 : 0);
            else n_pass++;
        end
        n_checks++; if (issued_cnt !== 8'd3) $display("FAIL busy_issued got %0d want 3", issued_cnt); else n_pass++;
    endtask

    task automatic test_fifo_full();
        do_reset(1'b1);
        for (int i = 1; i <= 8; i++) begin
            push(4'(i));
            if (i == 7) begin
                n_checks++; if (in_ready !== 1'b1) $display("FAIL full_ready7 got %0b want 1", in_ready); else n_pass++;
            end
        end
        n_checks++; if (in_ready !== 1'b0) $display("FAIL full_ready8 got %0b want 0", in_ready); else n_pass++;
        busy = 1'b0;
        tick();
        n_checks++; if (cmd_valid !== 1'b1) $display("FAIL full_first_pop got %0b want 1", cmd_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL full_ready_on_pop got %0b want 1", in_ready); else n_pass++;
        in_valid = 1'b1;
        in_cmd   = 4'd9;
        tick();
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL full_ready_after got %0b want 0", in_ready); else n_pass++;
        wait_strobes(9, 100);
        for (int i = 0; i < 9; i++) begin
            got = (strobes.size() > i) ? strobes[i] : 4'hx;
            n_checks++;
            if (got !== 4'(i + 1)) $display("FAIL full_order[%0d] got %0d want %0d", i, got, i + 1);
            else n_pass++;
        end
    endtask

    task automatic test_illegal();
        do_reset(1'b0);
        push(4'd13);
        n_checks++; if (err_illegal !== 1'b1) $display("FAIL ill_err got %0b want 1", err_illegal); else n_pass++;
        push(4'd4);
        repeat (20) tick();
        n_checks++; if (strobes.size() != 1) $display("FAIL ill_count got %0d want 1", strobes.size()); else n_pass++;
        got = (strobes.size() > 0) ? strobes[0] : 4'hx;
        n_checks++; if (got !== 4'd4) $display("FAIL ill_cmd got %0d want 4", got); else n_pass++;
        n_checks++; if (issued_cnt !== 8'd1) $display("FAIL ill_issued got %0d want 1", issued_cnt); else n_pass++;
        n_checks++; if (err_illegal !== 1'b1) $display("FAIL ill_sticky got %0b want 1", err_illegal); else n_pass++;
    endtask

    task automatic test_write_done();
        do_reset(1'b0);
        push(4'd0);
        push(4'd6);
        push(4'd7);
        wait_strobes(1, 20);
        repeat (64) tick();
        n_checks++; if (seq_done !== 1'b0) $display("FAIL wd_early_seq got %0b want 0", seq_done); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL wd_ready_wait got %0b want 1", in_ready); else n_pass++;
        done = 1'b1;
        tick();
        done = 1'b0;
        n_checks++; if (seq_done !== 1'b1) $display("FAIL wd_seq got %0b want 1", seq_done); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL wd_ready got %0b want 0", in_ready); else n_pass++;
        repeat (30) tick();
        n_checks++; if (strobes.size() != 1) $display("FAIL wd_flush got %0d strobes want 1", strobes.size()); else n_pass++;
        n_checks++; if (issued_cnt !== 8'd1) $display("FAIL wd_issued got %0d want 1", issued_cnt); else n_pass++;
        n_checks++; if (seq_done !== 1'b1) $display("FAIL wd_sticky got %0b want 1", seq_done); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int k = 0;
        do_reset(1'b0);
        push(4'd5);
        while (!cmd_valid && k < 20) begin
            tick();
            k++;
        end
        busy = 1'b1;
        repeat (4) tick();
        n_checks++; if (issued_cnt !== 8'd1) $display("FAIL mid_pre_issued got %0d want 1", issued_cnt); else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (issued_cnt !== 8'd0) $display("FAIL mid_issued got %0d want 0", issued_cnt); else n_pass++;
        n_checks++; if (cmd !== 4'd0) $display("FAIL mid_cmd got %0d want 0", cmd); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL mid_ready got %0b want 0", in_ready); else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        busy  = 1'b0;
        strobes.delete();
        tick();
        push(4'd2);
        wait_strobes(1, 20);
        got = (strobes.size() > 0) ? strobes[0] : 4'hx;
        n_checks++; if (got !== 4'd2) $display("FAIL mid_new_cmd got %0d want 2", got); else n_pass++;
        n_checks++; if (issued_cnt !== 8'd1) $display("FAIL mid_new_issued got %0d want 1", issued_cnt); else n_pass++;
    endtask

    task automatic test_autowrite();
        do_reset(1'b0);
        push(4'd1);
`ifdef LCD_ISSUER_AUTOWRITE_EN
        wait_strobes(2, 60);
        got = (strobes.size() > 1) ? strobes[1] : 4'hx;
        n_checks++; if (got !== 4'd0) $display("FAIL aw_cmd got %0d want 0", got); else n_pass++;
        n_checks++; if (issued_cnt !== 8'd2) $display("FAIL aw_issued got %0d want 2", issued_cnt); else n_pass++;
        repeat (3) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        n_checks++; if (seq_done !== 1'b1) $display("FAIL aw_seq got %0b want 1", seq_done); else n_pass++;
`else
        repeat (100) tick();
        n_checks++; if (strobes.size() != 1) $display("FAIL noaw_count got %0d want 1", strobes.size()); else n_pass++;
        n_checks++; if (issued_cnt !== 8'd1) $display("FAIL noaw_issued got %0d want 1", issued_cnt); else n_pass++;
`endif
    endtask

    task automatic test_strobe_width();
        n_checks++; if (n_dbl != 0) $display("FAIL strobe_width got %0d double strobes want 0", n_dbl); else n_pass++;
    endtask

    initial begin
        clk      = 1'b0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_cmd   = 4'd0;
        busy     = 1'b1;
        done     = 1'b0;
        #2;
        reset = 1'b0;
        test_reset();
        test_latency();
        test_busy_hold();
        test_fifo_full();
        test_illegal();
        test_write_done();
        test_reset_mid();
        test_autowrite();
        test_strobe_width();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
